// File: rtl/cpu_writeback.sv
// ============================================================================
// Module   : cpu_writeback
// Purpose  : moxie final stage - commits register writes and performs stores
//            via req/ack, stalling upstream while a store is in flight.
// Options  : `define MOXIE_WB_TIMEOUT_EN to build the store-abort watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  register_write_index_i,
  input  logic        register_write_enable_i,
  input  logic        memory_write_enable_i,
  input  logic [31:0] memory_write_address_i,
  input  logic [31:0] result_i,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [3:0]  reg_windex_o,
  output logic [31:0] reg_wdata_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  output logic        bus_error_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        reg_we_q, reg_we_d;
  logic [3:0]  reg_windex_q, reg_windex_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("cpu_writeback: TIMEOUT_CYCLES must lie in 1..255");
  end

`ifdef MOXIE_WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_error_q, bus_error_d;
  logic       timeout_hit;

  // Limit is reached on the edge that would complete the Nth unacked wait cycle.
  assign timeout_hit = (wait_cnt_q + 8'd1) == TIMEOUT_LIMIT;
`endif

  always_comb begin
    state_d      = state_q;
    reg_we_d     = 1'b0;
    reg_windex_d = reg_windex_q;
    reg_wdata_d  = reg_wdata_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
`ifdef MOXIE_WB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    bus_error_d  = bus_error_q;
`endif

    if (state_q == IDLE) begin
      if (register_write_enable_i) begin
        reg_we_d     = 1'b1;
        reg_windex_d = register_write_index_i;
        reg_wdata_d  = result_i;
      end
      if (memory_write_enable_i) begin
        dmem_req_d   = 1'b1;
        dmem_we_d    = 1'b1;
        dmem_addr_d  = memory_write_address_i;
        dmem_wdata_d = result_i;
        state_d      = MEM_WAIT;
`ifdef MOXIE_WB_TIMEOUT_EN
        wait_cnt_d   = 8'd0;
`endif
      end
    end else if (dmem_ack_i) begin
      // An ack on the limit edge is a normal completion, so it is tested first.
      dmem_req_d = 1'b0;
      dmem_we_d  = 1'b0;
      state_d    = IDLE;
    end
`ifdef MOXIE_WB_TIMEOUT_EN
    else if (timeout_hit) begin
      dmem_req_d  = 1'b0;
      dmem_we_d   = 1'b0;
      state_d     = IDLE;
      bus_error_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      reg_we_q     <= 1'b0;
      reg_windex_q <= 4'd0;
      reg_wdata_q  <= 32'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
`ifdef MOXIE_WB_TIMEOUT_EN
      wait_cnt_q   <= 8'd0;
      bus_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      reg_we_q     <= reg_we_d;
      reg_windex_q <= reg_windex_d;
      reg_wdata_q  <= reg_wdata_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
`ifdef MOXIE_WB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      bus_error_q  <= bus_error_d;
`endif
    end
  end

  assign stall_o      = (state_q == MEM_WAIT);
  assign reg_we_o     = reg_we_q;
  assign reg_windex_o = reg_windex_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
`ifdef MOXIE_WB_TIMEOUT_EN
  assign bus_error_o  = bus_error_q;
`else
  assign bus_error_o  = 1'b0;
`endif

endmodule

`default_nettype wire
